// File: rtl/proj_extender_stream_if.sv
// Bundles the job, fetch, fragment and output-beat handshakes of proj_extender_stream.
// Latency: none, wires only.
// Backpressure: carries in_ready, fetch_ready and out_ready between the block and its neighbours.
interface proj_extender_stream_if #(
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 5,
    parameter int FRAG_LEN      = 16,
    parameter int FRAG_PART     = 4
);
    localparam int PARTS = FRAG_LEN / FRAG_PART;
    localparam int SIDX  = INDICE_LEN + 1;
    localparam int KW    = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1;

    // job input
    logic                                in_valid;
    logic                                in_ready;
    logic [INDICES_COUNT*INDICE_LEN-1:0] in_kmer_indices;
    logic                                in_reverse;

    // fragment request to sequence memory
    logic                                fetch_valid;
    logic                                fetch_ready;
    logic signed [SIDX-1:0]              fetch_index;

    // fragment returned by sequence memory
    logic                                frag_valid;
    logic [FRAG_LEN-1:0]                 in_fragment;

    // output beats
    logic                                out_valid;
    logic                                out_ready;
    logic [FRAG_PART-1:0]                out_gfm;
    logic [KW-1:0]                       out_kmer_id;
    logic [PW-1:0]                       out_part_id;
    logic                                out_last;
    logic                                busy;

    // block side
    modport master (
        input  in_valid, in_kmer_indices, in_reverse,
        input  fetch_ready, frag_valid, in_fragment, out_ready,
        output in_ready, fetch_valid, fetch_index,
        output out_valid, out_gfm, out_kmer_id, out_part_id, out_last, busy
    );

    // environment side
    modport slave (
        output in_valid, in_kmer_indices, in_reverse,
        output fetch_ready, frag_valid, in_fragment, out_ready,
        input  in_ready, fetch_valid, fetch_index,
        input  out_valid, out_gfm, out_kmer_id, out_part_id, out_last, busy
    );
endinterface

// File: rtl/proj_extender_stream.sv
// Expands each k-mer index of a job into a masked FRAG_LEN-bit window from sequence memory, streamed as FRAG_PART-bit beats.
// Latency: fetch request 1 cycle after job accept; first beat 1 cycle after fragment capture; back-to-back beats when unstalled.
// Backpressure: no new job while busy; fetch request and output beat hold stable until fetch_ready / out_ready.
module proj_extender_stream #(
    parameter int KMER_LEN      = 4,
    parameter int BASE_LEN      = 2,
    parameter int FRAG_LEN      = 16,
    parameter int FRAG_PART     = 4,
    parameter int INDICES_COUNT = 4,
    parameter int INDICE_LEN    = 5,
    parameter int SEQ_LEN       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    proj_extender_stream_if.master  bus
);
    localparam int EXT   = (FRAG_LEN - KMER_LEN * BASE_LEN) / 2;
    localparam int PARTS = FRAG_LEN / FRAG_PART;
    localparam int SIDX  = INDICE_LEN + 1;
    localparam int KW    = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t                              state_q;
    state_t                              state_d;

    logic [INDICES_COUNT*INDICE_LEN-1:0] idx_q;
    logic                                rev_q;
    logic [KW-1:0]                       k_q;
    logic [PW-1:0]                       p_q;
    logic [FRAG_LEN-1:0]                 frag_q;

    logic [INDICE_LEN-1:0]               cur_idx;
    logic signed [SIDX-1:0]              win_start;
    logic [FRAG_LEN-1:0]                 frag_masked;
    logic [PW-1:0]                       part_sel;
    logic                                last_part;
    logic                                last_k;
    logic                                job_acc;

    logic                                in_ready_c;
    logic                                fetch_valid_c;
    logic signed [SIDX-1:0]              fetch_index_c;
    logic                                out_valid_c;
    logic [FRAG_PART-1:0]                out_gfm_c;
    logic [KW-1:0]                       out_kmer_id_c;
    logic [PW-1:0]                       out_part_id_c;
    logic                                out_last_c;
    logic                                busy_c;

    // Window start is signed because indices near the sequence head push it below zero.
    assign cur_idx   = idx_q[k_q*INDICE_LEN +: INDICE_LEN];
    assign win_start = $signed({1'b0, cur_idx}) - $signed(SIDX'(EXT));

    // Reverse mode walks the parts from the top; part_id always names the natural part.
    assign part_sel  = rev_q ? (PW'(PARTS - 1) - p_q) : p_q;
    assign last_part = (p_q == PW'(PARTS - 1));
    assign last_k    = (k_q == KW'(INDICES_COUNT - 1));
    assign job_acc   = bus.in_valid && in_ready_c;

    // Clear fragment bits whose sequence position lies before 0 or at/after SEQ_LEN.
    always_comb begin
        int pos;
        pos         = 0;
        frag_masked = bus.in_fragment;
        for (int i = 0; i < FRAG_LEN; i++) begin
            pos = int'(win_start) + i;
            if (pos < 0 || pos >= SEQ_LEN) begin
                frag_masked[i] = 1'b0;
            end
        end
    end

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; every output is zero outside the state that owns it.
    always_comb begin
        state_d       = state_q;
        in_ready_c    = 1'b0;
        fetch_valid_c = 1'b0;
        fetch_index_c = '0;
        out_valid_c   = 1'b0;
        out_gfm_c     = '0;
        out_kmer_id_c = '0;
        out_part_id_c = '0;
        out_last_c    = 1'b0;
        busy_c        = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                in_ready_c = !rst;
                if (bus.in_valid && !rst) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_valid_c = 1'b1;
                fetch_index_c = win_start;
                if (bus.fetch_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.frag_valid) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid_c   = 1'b1;
                out_gfm_c     = frag_q[part_sel*FRAG_PART +: FRAG_PART];
                out_kmer_id_c = k_q;
                out_part_id_c = part_sel;
                out_last_c    = last_part && last_k;
                if (bus.out_ready && last_part) begin
                    state_d = last_k ? S_IDLE : S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Job registers: indices and order latched at accept, fragment at capture, counters on beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            rev_q  <= 1'b0;
            k_q    <= '0;
            p_q    <= '0;
            frag_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (job_acc) begin
                        idx_q <= bus.in_kmer_indices;
                        rev_q <= bus.in_reverse;
                        k_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (bus.frag_valid) begin
                        frag_q <= frag_masked;
                        p_q    <= '0;
                    end
                end
                S_EMIT: begin
                    if (bus.out_ready) begin
                        if (!last_part) begin
                            p_q <= p_q + 1'b1;
                        end else if (!last_k) begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.fetch_valid = fetch_valid_c;
    assign bus.fetch_index = fetch_index_c;
    assign bus.out_valid   = out_valid_c;
    assign bus.out_gfm     = out_gfm_c;
    assign bus.out_kmer_id = out_kmer_id_c;
    assign bus.out_part_id = out_part_id_c;
    assign bus.out_last    = out_last_c;
    assign bus.busy        = busy_c;

endmodule

// File: tb/tb_proj_extender_stream.sv
// Directed and stalled jobs against proj_extender_stream with hand-computed beats plus a masking model.
// Latency: checks fetch 1 cycle after accept and beat order/flags per cycle.
// Backpressure: drives random fetch_ready/out_ready and checks beats hold while stalled.
module tb_proj_extender_stream;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    proj_extender_stream_if #(
        .INDICES_COUNT(4), .INDICE_LEN(5), .FRAG_LEN(16), .FRAG_PART(4)
    ) bus ();

    proj_extender_stream #(
        .KMER_LEN(4), .BASE_LEN(2), .FRAG_LEN(16), .FRAG_PART(4),
        .INDICES_COUNT(4), .INDICE_LEN(5), .SEQ_LEN(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Window start = idx - 4; zero bits whose position is outside 0..31.
    function automatic logic [15:0] mask_model(input logic [4:0] idx, input logic [15:0] f);
        logic [15:0] m;
        int ws;
        int pos;
        m  = f;
        ws = int'(idx) - 4;
        for (int i = 0; i < 16; i++) begin
            pos = ws + i;
            if (pos < 0 || pos >= 32) m[i] = 1'b0;
        end
        return m;
    endfunction

    task automatic drive_idle();
        bus.in_valid        = 1'b0;
        bus.in_kmer_indices = '0;
        bus.in_reverse      = 1'b0;
        bus.fetch_ready     = 1'b0;
        bus.frag_valid      = 1'b0;
        bus.in_fragment     = '0;
        bus.out_ready       = 1'b0;
    endtask

    // Assert reset now, check outputs drop at once, release after two cycles.
    task automatic reset_pulse();
        rst = 1'b1;
        drive_idle();
        #1;
        chk("rst_outs", 64'({bus.in_ready, bus.fetch_valid, bus.fetch_index, bus.out_valid,
                             bus.out_gfm, bus.out_kmer_id, bus.out_part_id, bus.out_last,
                             bus.busy}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rel_novld", 64'(bus.out_valid), 64'd0);
        end
    endtask

    // Called at a negedge with the block idle.
    task automatic run_job(input logic [19:0] idxs, input logic rev, input logic [63:0] frags,
                           input bit use_model, input logic [63:0] hgfm, input logic [31:0] hpid,
                           input logic [23:0] hfidx, input bit stalls, input bit abort);
        logic [3:0]  q_gfm[$];
        logic [1:0]  q_pid[$];
        logic [5:0]  q_fidx[$];
        logic [15:0] m;
        logic [4:0]  idx;
        logic [1:0]  pp;
        int          beat;
        int          k_frag;
        int          dly;
        int          cyc;
        bit          wait_frag;
        bit          prev_stall;
        bit          done;
        bit          r;

        for (int k = 0; k < 4; k++) begin
            idx = idxs[k*5 +: 5];
            q_fidx.push_back(use_model ? ({1'b0, idx} - 6'd4) : hfidx[k*6 +: 6]);
            m = mask_model(idx, frags[k*16 +: 16]);
            for (int p = 0; p < 4; p++) begin
                pp = rev ? 2'(3 - p) : 2'(p);
                q_gfm.push_back(use_model ? m[pp*4 +: 4] : hgfm[(k*4+p)*4 +: 4]);
                q_pid.push_back(use_model ? pp : hpid[(k*4+p)*2 +: 2]);
            end
        end

        chk("idle_rdy", 64'(bus.in_ready), 64'd1);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        bus.in_valid        = 1'b1;
        bus.in_kmer_indices = idxs;
        bus.in_reverse      = rev;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_reverse = ~rev;
        chk("fetch_lat", 64'(bus.fetch_valid), 64'd1);

        beat = 0; k_frag = 0; dly = 0; cyc = 0;
        wait_frag = 1'b0; prev_stall = 1'b0; done = 1'b0;
        while (!done && cyc < 400) begin
            chk("job_rdy", 64'(bus.in_ready), 64'd0);
            chk("job_busy", 64'(bus.busy), 64'd1);
            if (prev_stall) chk("hold_vld", 64'(bus.out_valid), 64'd1);
            if (bus.fetch_valid) begin
                if (q_fidx.size() != 0) chk("fidx", 64'({bus.fetch_index}), 64'(q_fidx[0]));
                else chk("extra_fetch", 64'd1, 64'd0);
            end
            if (bus.out_valid) begin
                if (q_gfm.size() != 0) begin
                    chk("gfm", 64'(bus.out_gfm), 64'(q_gfm[0]));
                    chk("pid", 64'(bus.out_part_id), 64'(q_pid[0]));
                    chk("kid", 64'(bus.out_kmer_id), 64'(beat / 4));
                    chk("last", 64'(bus.out_last), 64'(beat == 15));
                end else begin
                    chk("extra_beat", 64'd1, 64'd0);
                end
            end
            if (abort && bus.out_valid && bus.out_kmer_id == 2'd2) begin
                reset_pulse();
                return;
            end

            // Fragment: real data in WAIT, ignorable junk with frag_valid high otherwise.
            if (wait_frag) begin
                if (dly == 0) begin
                    bus.frag_valid  = 1'b1;
                    bus.in_fragment = frags[k_frag*16 +: 16];
                    k_frag++;
                    wait_frag = 1'b0;
                end else begin
                    bus.frag_valid = 1'b0;
                    dly--;
                end
            end else begin
                bus.frag_valid  = 1'b1;
                bus.in_fragment = 16'h5A5A;
            end

            if (bus.fetch_valid) begin
                r = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.fetch_ready = r;
                if (r) begin
                    if (q_fidx.size() != 0) void'(q_fidx.pop_front());
                    wait_frag = 1'b1;
                    dly = stalls ? int'($urandom_range(0, 2)) : 0;
                end
            end else begin
                bus.fetch_ready = 1'b0;
            end

            if (bus.out_valid) begin
                r = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.out_ready = r;
                prev_stall = !r;
                if (r) begin
                    if (beat == 15) done = 1'b1;
                    beat++;
                    if (q_gfm.size() != 0) begin
                        void'(q_gfm.pop_front());
                        void'(q_pid.pop_front());
                    end
                end
            end else begin
                bus.out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b0;
                prev_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) chk("timeout", 64'd0, 64'd1);
        drive_idle();
        chk("end_rdy", 64'(bus.in_ready), 64'd1);
        chk("end_busy", 64'(bus.busy), 64'd0);
        chk("end_vld", 64'(bus.out_valid), 64'd0);
        chk("end_left", 64'(q_gfm.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        #1;
        chk("init_outs", 64'({bus.in_ready, bus.fetch_valid, bus.fetch_index, bus.out_valid,
                              bus.out_gfm, bus.out_kmer_id, bus.out_part_id, bus.out_last,
                              bus.busy}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Index 10 x4, fragment A5C3, forward: beats 3,C,5,A, fetch_index 6.
        run_job({5'd10, 5'd10, 5'd10, 5'd10}, 1'b0, {4{16'hA5C3}}, 1'b0,
                64'hA5C3_A5C3_A5C3_A5C3, 32'hE4E4_E4E4, {4{6'd6}}, 1'b0, 1'b0);
        // Indices 1,30,10,10 with all-ones memory: FFF8, 003F, FFFF, FFFF.
        run_job({5'd10, 5'd10, 5'd30, 5'd1}, 1'b0, {4{16'hFFFF}}, 1'b0,
                64'hFFFF_FFFF_003F_FFF8, 32'hE4E4_E4E4, {6'd6, 6'd6, 6'd26, 6'h3D}, 1'b0, 1'b0);
        // Reverse order: beats A,5,C,3 with part ids 3,2,1,0.
        run_job({5'd10, 5'd10, 5'd10, 5'd10}, 1'b1, {4{16'hA5C3}}, 1'b0,
                64'h3C5A_3C5A_3C5A_3C5A, 32'h1B1B_1B1B, {4{6'd6}}, 1'b0, 1'b0);
        // Random indices/fragments with stalls, checked against the masking model.
        for (int j = 0; j < 4; j++) begin
            run_job(20'($urandom), 1'($urandom), {$urandom, $urandom}, 1'b1,
                    64'd0, 32'd0, 24'd0, 1'b1, 1'b0);
        end
        // Reset during EMIT of index 2, then a clean job from kmer 0.
        run_job({5'd10, 5'd10, 5'd10, 5'd10}, 1'b0, {4{16'hA5C3}}, 1'b0,
                64'hA5C3_A5C3_A5C3_A5C3, 32'hE4E4_E4E4, {4{6'd6}}, 1'b0, 1'b1);
        run_job({5'd10, 5'd10, 5'd30, 5'd1}, 1'b0, {4{16'hFFFF}}, 1'b0,
                64'hFFFF_FFFF_003F_FFF8, 32'hE4E4_E4E4, {6'd6, 6'd6, 6'd26, 6'h3D}, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
